// File: rtl/riscv_defines_pkg.sv
// rtl/riscv_defines_pkg.sv - shared AXI encodings and cache geometry
package riscv_defines_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int ICACHE_LINE_SIZE = 32;
endpackage

// File: rtl/axi_read_if.sv
// rtl/axi_read_if.sv - AXI read address/data channel bundle
interface axi_read_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);
    // last=1 means port 1 was served last, so port 0 wins a tie
    assign grant[0] = req0 && (!req1 || last);
    assign grant[1] = req1 && (!req0 || !last);
endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-port cache refill arbiter onto one AXI read burst master
module axi_read_arbiter
    import riscv_defines_pkg::*;
#(
    parameter int LINE_BYTES = ICACHE_LINE_SIZE,
    parameter int ADDR_W     = AXI_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s0_req_valid,
    input  logic [ADDR_W-1:0]       s0_req_addr,
    output logic                    s0_resp_valid,
    input  logic                    s1_req_valid,
    input  logic [ADDR_W-1:0]       s1_req_addr,
    output logic                    s1_resp_valid,
    output logic [LINE_BYTES*8-1:0] resp_data,
    axi_read_if.master              axi_if
);
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t                  state, state_next;
    logic                    pend0, pend1;
    logic [ADDR_W-1:0]       addr0, addr1;
    logic                    rr_ptr;
    logic                    gnt_port;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [WORDS-1:0][31:0]  line;
    logic [ADDR_W-1:0]       araddr_q;
    logic                    want0, want1;
    logic [1:0]              grant;

    assign want0 = pend0 || s0_req_valid;
    assign want1 = pend1 || s1_req_valid;

    // rr_ptr names the port holding priority; the arbiter wants the last-served one
    rr_arb2 u_arb (
        .req0  (want0),
        .req1  (want1),
        .last  (~rr_ptr),
        .grant (grant)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (want0 || want1) state_next = AR;
            AR:      if (axi_if.arready) state_next = R;
            R:       if (axi_if.rvalid && axi_if.rlast) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            addr0    <= '0;
            addr1    <= '0;
            rr_ptr   <= 1'b0;
            gnt_port <= 1'b0;
            beat_cnt <= '0;
            line     <= '0;
            araddr_q <= '0;
        end else begin
            state <= state_next;
            if (s0_req_valid && !pend0) begin
                pend0 <= 1'b1;
                addr0 <= s0_req_addr;
            end
            if (s1_req_valid && !pend1) begin
                pend1 <= 1'b1;
                addr1 <= s1_req_addr;
            end
            case (state)
                IDLE: begin
                    if (want0 || want1) begin
                        gnt_port <= grant[1];
                        if (grant[1]) araddr_q <= pend1 ? addr1 : s1_req_addr;
                        else          araddr_q <= pend0 ? addr0 : s0_req_addr;
                    end
                end
                AR: begin
                    if (axi_if.arready) beat_cnt <= '0;
                end
                R: begin
                    if (axi_if.rvalid) begin
                        line[beat_cnt] <= axi_if.rdata;
                        beat_cnt       <= beat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (gnt_port) pend1 <= 1'b0;
                    else          pend0 <= 1'b0;
                    rr_ptr <= ~gnt_port;
                end
                default: ;
            endcase
        end
    end

    assign axi_if.arvalid = (state == AR);
    assign axi_if.araddr  = araddr_q;
    assign axi_if.arlen   = 8'(WORDS - 1);
    assign axi_if.arsize  = AXI_SIZE_4B;
    assign axi_if.arburst = AXI_BURST_INCR;
    assign axi_if.rready  = (state == R);

    assign s0_resp_valid = (state == RESP) && !gnt_port;
    assign s1_resp_valid = (state == RESP) && gnt_port;
    assign resp_data     = line;
endmodule
